// File: rtl/rbzero_tex_pkg.sv
// Shared constants and state encoding for the texture-flash SPI reader.
package rbzero_tex_pkg;

    localparam int unsigned CMD_BITS        = 8;
    localparam int unsigned ADDR_PHASE_BITS = 24;
    localparam logic [7:0]  READ_CMD        = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        GAP
    } tex_state_t;

endpackage

// File: rtl/tex_spi_bitclk.sv
// SPI bit-cell timing: a phase toggle (L/H half of each cell) and a counter of
// completed cells. sclk is the phase flop itself, so it idles low whenever
// run is deasserted and always returns low on the edge that ends a cell.
module tex_spi_bitclk #(
    parameter  int unsigned TOTAL_BITS = 40,
    localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    output logic             phase,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             cell_end,
    output logic             done
);

    logic last_bit;

    assign cell_end = run && phase;
    assign last_bit = (bit_cnt == CNT_W'(TOTAL_BITS - 1));
    assign done     = cell_end && last_bit;

    // Phase toggles every clk while running; counter advances as each cell ends.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (run) begin
            phase <= ~phase;
            if (phase) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tex_spi_reader.sv
// Single-SPI (READ 0x03) master fetching one texel per request from the
// texture flash. SCLK = clk/2, mode 0; one transfer in flight at a time.
module tex_spi_reader
    import rbzero_tex_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 24,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CS_GAP    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_tex_csb,
    output logic                 o_tex_sclk,
    output logic                 o_tex_oeb0,
    output logic                 o_tex_out0,
    input  logic [3:0]           i_tex_in
);

    localparam int unsigned TX_BITS    = CMD_BITS + ADDR_PHASE_BITS;
    localparam int unsigned TOTAL_BITS = TX_BITS + DATA_BITS;
    localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 1);
    localparam int unsigned GAP_W      = $clog2(CS_GAP + 1);

    tex_state_t                 state;
    logic [TX_BITS-1:0]         tx;
    logic [DATA_BITS-1:0]       rx;
    logic [DATA_BITS-1:0]       rx_next;
    logic [GAP_W-1:0]           gap_cnt;
    logic [ADDR_PHASE_BITS-1:0] addr_ext;
    logic                       start;
    logic                       run;
    logic                       phase;
    logic [CNT_W-1:0]           bit_cnt;
    logic                       cell_end;
    logic                       done;
    logic                       unused_pads;

    // Address is zero-extended (or truncated) to the fixed 24-bit command field.
    assign addr_ext    = ADDR_PHASE_BITS'(i_addr);
    assign start       = (state == IDLE) && i_req && !o_busy;
    assign run         = (state == CMD) || (state == ADDR) || (state == DATA);
    assign rx_next     = (rx << 1) | DATA_BITS'(i_tex_in[1]);
    assign o_tex_sclk  = phase;
    assign unused_pads = ^{i_tex_in[3:2], i_tex_in[0]};

    tex_spi_bitclk #(
        .TOTAL_BITS(TOTAL_BITS)
    ) u_bitclk (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .run     (run),
        .phase   (phase),
        .bit_cnt (bit_cnt),
        .cell_end(cell_end),
        .done    (done)
    );

    // Transfer FSM with the command/address and data shift registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_tex_csb  <= 1'b1;
            o_tex_oeb0 <= 1'b1;
            o_tex_out0 <= 1'b0;
            tx         <= '0;
            rx         <= '0;
            gap_cnt    <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CMD;
                        o_busy     <= 1'b1;
                        o_tex_csb  <= 1'b0;
                        o_tex_oeb0 <= 1'b0;
                        tx         <= {READ_CMD, addr_ext};
                        o_tex_out0 <= READ_CMD[CMD_BITS-1];
                        rx         <= '0;
                    end
                end
                CMD: begin
                    if (cell_end) begin
                        tx         <= tx << 1;
                        o_tex_out0 <= tx[TX_BITS-2];
                        if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (cell_end) begin
                        if (bit_cnt == CNT_W'(TX_BITS - 1)) begin
                            state      <= DATA;
                            o_tex_out0 <= 1'b0;
                            o_tex_oeb0 <= 1'b1;
                        end else begin
                            tx         <= tx << 1;
                            o_tex_out0 <= tx[TX_BITS-2];
                        end
                    end
                end
                DATA: begin
                    if (cell_end) begin
                        rx <= rx_next;
                        if (done) begin
                            state     <= GAP;
                            o_tex_csb <= 1'b1;
                            o_data    <= rx_next;
                            o_valid   <= 1'b1;
                            gap_cnt   <= GAP_W'(CS_GAP - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tex_spi_reader.sv
// Directed bench for tex_spi_reader: an 8-bit build and a 6-bit build, each
// talking to a small behavioural READ-command flash model.
module tb_tex_spi_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // ---------------- 8-bit build ----------------
    logic        req = 1'b0;
    logic [23:0] addr = '0;
    logic        busy, valid, csb, sclk, oeb0, out0;
    logic [7:0]  data;
    logic        miso = 1'b0;
    logic [3:0]  tex_in;

    assign tex_in = {2'b11, miso, 1'b1};

    tex_spi_reader #(
        .ADDR_BITS(24),
        .DATA_BITS(8),
        .CS_GAP   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (req),
        .i_addr    (addr),
        .o_busy    (busy),
        .o_valid   (valid),
        .o_data    (data),
        .o_tex_csb (csb),
        .o_tex_sclk(sclk),
        .o_tex_oeb0(oeb0),
        .o_tex_out0(out0),
        .i_tex_in  (tex_in)
    );

    // ---------------- 6-bit build ----------------
    logic        req6 = 1'b0;
    logic [23:0] addr6 = '0;
    logic        busy6, valid6, csb6, sclk6, oeb06, out06;
    logic [5:0]  data6;
    logic        miso6 = 1'b0;
    logic [3:0]  tex_in6;

    assign tex_in6 = {2'b00, miso6, 1'b0};

    tex_spi_reader #(
        .ADDR_BITS(24),
        .DATA_BITS(6),
        .CS_GAP   (2)
    ) dut6 (
        .clk       (clk),
        .reset     (reset),
        .i_req     (req6),
        .i_addr    (addr6),
        .o_busy    (busy6),
        .o_valid   (valid6),
        .o_data    (data6),
        .o_tex_csb (csb6),
        .o_tex_sclk(sclk6),
        .o_tex_oeb0(oeb06),
        .o_tex_out0(out06),
        .i_tex_in  (tex_in6)
    );

    // ---------------- flash models ----------------
    // Command/address captured on sclk rising edges; data bit n is presented
    // from rising edge 32+n so the master sees it on the following fall.
    logic [7:0]  fl_byte = '0;
    logic [31:0] fl_mosi = '0;
    int          fl_rises = 0;
    int          fl_xfers = 0;

    always @(negedge csb) begin
        fl_rises = 0;
        fl_xfers = fl_xfers + 1;
        miso     = 1'b0;
    end

    always @(posedge sclk) begin
        if (csb == 1'b0) begin
            if (fl_rises < 32) fl_mosi = {fl_mosi[30:0], out0};
            else if (fl_rises < 40) miso = fl_byte[39 - fl_rises];
            fl_rises = fl_rises + 1;
        end
    end

    logic [7:0]  fl6_byte = '0;
    logic [31:0] fl6_mosi = '0;
    int          fl6_rises = 0;

    always @(negedge csb6) begin
        fl6_rises = 0;
        miso6     = 1'b0;
    end

    always @(posedge sclk6) begin
        if (csb6 == 1'b0) begin
            if (fl6_rises < 32) fl6_mosi = {fl6_mosi[30:0], out06};
            else if (fl6_rises < 40) miso6 = fl6_byte[39 - fl6_rises];
            fl6_rises = fl6_rises + 1;
        end
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows one 8-bit transfer from the sample just after the accepting
    // edge (k=0) up to the o_valid sample, collecting timing/direction errors.
    task automatic track(output int valid_at, output int csb_low, output int oeb_err,
                         output int out0_err, output int sclk_err, output logic [7:0] got);
        int k;
        k        = 0;
        csb_low  = 0;
        oeb_err  = 0;
        out0_err = 0;
        sclk_err = 0;
        got      = '0;
        valid_at = -1;
        while (valid_at < 0 && k <= 200) begin
            if (csb == 1'b0) csb_low++;
            if (oeb0 !== (k >= 64)) oeb_err++;
            if (k >= 64 && out0 !== 1'b0) out0_err++;
            if (sclk !== ((k < 80) && (k % 2 == 1))) sclk_err++;
            if (valid === 1'b1) begin
                valid_at = k;
                got      = data;
            end else begin
                tick();
                k++;
            end
        end
    endtask

    int          v_at, c_low, e_oeb, e_out0, e_sclk, g, x0, toggles;
    logic [7:0]  got;
    logic        busy_at_gap;

    initial begin
        // Reset, then idle.
        repeat (3) tick();
        reset = 1'b0;
        check("rst_csb", csb, 1);
        check("rst_sclk", sclk, 0);
        check("rst_oeb0", oeb0, 1);
        check("rst_out0", out0, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        toggles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sclk !== 1'b0 || csb !== 1'b1 || valid !== 1'b0) toggles++;
        end
        check("idle_quiet", toggles, 0);

        // Single read of 0x012345 returning 0xA5.
        fl_byte = 8'hA5;
        addr    = 24'h012345;
        req     = 1'b1;
        tick();
        req  = 1'b0;
        addr = 24'hFFFFFF;
        check("e0_busy", busy, 1);
        check("e0_csb", csb, 0);
        check("e0_oeb0", oeb0, 0);
        check("e0_out0", out0, 0);
        track(v_at, c_low, e_oeb, e_out0, e_sclk, got);
        check("a5_latency", v_at, 80);
        check("a5_data", got, 8'hA5);
        check("a5_csb_low", c_low, 80);
        check("a5_oeb_dir", e_oeb, 0);
        check("a5_out0_data", e_out0, 0);
        check("a5_sclk", e_sclk, 0);
        check("a5_mosi", fl_mosi, 32'h03012345);
        tick();
        check("a5_pulse_len", valid, 0);
        check("a5_hold", data, 8'hA5);
        repeat (5) tick();

        // Back-to-back with i_req held high throughout.
        x0      = fl_xfers;
        fl_byte = 8'h3C;
        addr    = 24'h000010;
        req     = 1'b1;
        tick();
        addr = 24'h000011;
        track(v_at, c_low, e_oeb, e_out0, e_sclk, got);
        check("b1_latency", v_at, 80);
        check("b1_data", got, 8'h3C);
        check("b1_mosi", fl_mosi, 32'h03000010);
        fl_byte     = 8'hC3;
        g           = 0;
        busy_at_gap = 1'b1;
        while (csb === 1'b1 && g < 20) begin
            tick();
            g++;
            if (g == 2) busy_at_gap = busy;
        end
        check("b2_gap", g, 3);
        check("b2_busy_drop", busy_at_gap, 0);
        track(v_at, c_low, e_oeb, e_out0, e_sclk, got);
        req = 1'b0;
        check("b2_latency", v_at, 80);
        check("b2_data", got, 8'hC3);
        check("b2_mosi", fl_mosi, 32'h03000011);
        repeat (10) tick();
        check("b2_xfers", fl_xfers - x0, 2);
        check("b2_idle_busy", busy, 0);

        // Reset mid-ADDR, with i_req also high while reset is asserted.
        fl_byte = 8'hFF;
        addr    = 24'h0ABCDE;
        req     = 1'b1;
        tick();
        req = 1'b0;
        repeat (39) tick();
        reset = 1'b1;
        req   = 1'b1;
        tick();
        check("mr_csb", csb, 1);
        check("mr_sclk", sclk, 0);
        check("mr_busy", busy, 0);
        check("mr_valid", valid, 0);
        check("mr_data", data, 0);
        check("mr_oeb0", oeb0, 1);
        tick();
        check("mr_req_ignored", {busy, csb}, 2'b01);
        reset = 1'b0;
        req   = 1'b0;
        tick();
        check("mr_post_busy", busy, 0);
        fl_byte = 8'h5A;
        addr    = 24'h000000;
        req     = 1'b1;
        tick();
        req = 1'b0;
        track(v_at, c_low, e_oeb, e_out0, e_sclk, got);
        check("mr_latency", v_at, 80);
        check("mr_data_after", got, 8'h5A);
        check("mr_mosi", fl_mosi, 32'h03000000);

        // 6-bit build.
        fl6_byte = 8'b1011_0111;
        addr6    = 24'h000123;
        req6     = 1'b1;
        tick();
        req6 = 1'b0;
        v_at  = -1;
        c_low = 0;
        for (int k = 0; k <= 200 && v_at < 0; k++) begin
            if (csb6 == 1'b0) c_low++;
            if (valid6 === 1'b1) begin
                v_at = k;
                check("d6_data", data6, 6'b101101);
                check("d6_oeb0", oeb06, 1);
                check("d6_busy", busy6, 1);
            end else begin
                tick();
            end
        end
        check("d6_latency", v_at, 76);
        check("d6_csb_low", c_low, 76);
        check("d6_mosi", fl6_mosi, 32'h03000123);
        check("d6_sclk_idle", sclk6, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
